windowed_regfile_ctl: RTL



---
 rtl/wrf_pkg.sv | 18 +
 rtl/windowed_regfile_ctl_if.sv | 22 ++
 rtl/wrf_array.sv | 34 +++
 rtl/windowed_regfile_ctl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/wrf_pkg.sv
// Shared types and the logical-to-physical register mapping for the windowed register file.
package wrf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPILL = 2'd1,
    FILL  = 2'd2
  } wrf_state_e;

  // Physical slot of a logical register in window cwp on a circular array of nphys words
  function automatic int unsigned phys_idx(input int unsigned cwp,
                                           input int unsigned logical,
                                           input int unsigned stride,
                                           input int unsigned nphys);
    return (cwp * stride + logical) % nphys;
  endfunction

endpackage

// File: rtl/windowed_regfile_ctl_if.sv
// Backing-stack memory port: req/ack handshake for spill writes and fill reads.
interface windowed_regfile_ctl_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MEM_AW = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/wrf_array.sv
// Physical register array: one write port, two operand read ports and one spill read port.
module wrf_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NPHYS  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic [$clog2(NPHYS)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(NPHYS)-1:0] raddr1_i,
  input  logic [$clog2(NPHYS)-1:0] raddr2_i,
  input  logic [$clog2(NPHYS)-1:0] raddr3_i,
  output logic [DATA_W-1:0]        rdata1_c,
  output logic [DATA_W-1:0]        rdata2_c,
  output logic [DATA_W-1:0]        rdata3_c
);

  logic [DATA_W-1:0] regs_q [NPHYS];

  // Storage with synchronous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NPHYS); i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_c = regs_q[raddr1_i];
  assign rdata2_c = regs_q[raddr2_i];
  assign rdata3_c = regs_q[raddr3_i];

endmodule

// File: rtl/windowed_regfile_ctl.sv
// Windowed register file controller: call/ret window moves with spill/fill of the oldest window.
module windowed_regfile_ctl
  import wrf_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned STRIDE = 2,
  parameter int unsigned NWIN   = 4,
  parameter int unsigned MEM_AW = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [$clog2(2*STRIDE)-1:0] rr1,
  input  logic [$clog2(2*STRIDE)-1:0] rr2,
  input  logic [$clog2(2*STRIDE)-1:0] wr,
  input  logic                        we,
  input  logic [DATA_W-1:0]           data_in,
  output logic [DATA_W-1:0]           r1,
  output logic [DATA_W-1:0]           r2,
  input  logic                        call,
  input  logic                        ret,
  output logic                        busy,
  output logic [$clog2(NWIN)-1:0]     cwp,
  output logic                        err,
  windowed_regfile_ctl_if.master      mem
);

  localparam int unsigned P        = NWIN * STRIDE;
  localparam int unsigned CW       = $clog2(NWIN);
  localparam int unsigned PW       = $clog2(P);
  localparam int unsigned IW       = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int unsigned SW       = MEM_AW + 1;
  localparam int unsigned SP_LIMIT = (1 << MEM_AW) - STRIDE;

  wrf_state_e        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cwp_q, cwp_d;
  logic [CW-1:0]     res_q, res_d;
  logic [SW-1:0]     sp_q, sp_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              arr_we_c;
  logic [PW-1:0]     arr_waddr_c;
  logic [DATA_W-1:0] arr_wdata_c;
  logic [PW-1:0]     spill_raddr_c;
  logic [DATA_W-1:0] spill_rdata_c;

  logic [CW-1:0]     cwp_inc_c, cwp_dec_c, oldest_c;
  logic              last_word_c;

  assign cwp_inc_c   = CW'((32'(cwp_q) + 32'd1) % NWIN);
  assign cwp_dec_c   = CW'((32'(cwp_q) + NWIN - 32'd1) % NWIN);
  assign oldest_c    = CW'((32'(cwp_q) + NWIN + 32'd1 - 32'(res_q)) % NWIN);
  assign last_word_c = (idx_q == IW'(STRIDE - 1));

  wrf_array #(
    .DATA_W (DATA_W),
    .NPHYS  (P)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (arr_we_c),
    .waddr_i  (arr_waddr_c),
    .wdata_i  (arr_wdata_c),
    .raddr1_i (PW'(phys_idx(32'(cwp_q), 32'(rr1), STRIDE, P))),
    .raddr2_i (PW'(phys_idx(32'(cwp_q), 32'(rr2), STRIDE, P))),
    .raddr3_i (spill_raddr_c),
    .rdata1_c (r1),
    .rdata2_c (r2),
    .rdata3_c (spill_rdata_c)
  );

  // Next-state logic: window moves, spill/fill sequencing and array write-port mux
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cwp_d       = cwp_q;
    res_d       = res_q;
    sp_d        = sp_q;
    err_d       = 1'b0;
    arr_we_c    = 1'b0;
    arr_waddr_c = PW'(phys_idx(32'(cwp_q), 32'(wr), STRIDE, P));
    arr_wdata_c = data_in;
    unique case (state_q)
      IDLE: begin
        arr_we_c = we;
        if (call && ret) begin
          err_d = 1'b1;
        end else if (call) begin
          if (32'(res_q) < NWIN - 1) begin
            cwp_d = cwp_inc_c;
            res_d = res_q + CW'(1);
          end else if (32'(sp_q) > SP_LIMIT) begin
            err_d = 1'b1;
          end else begin
            state_d = SPILL;
            idx_d   = '0;
          end
        end else if (ret) begin
          if (res_q > CW'(1)) begin
            cwp_d = cwp_dec_c;
            res_d = res_q - CW'(1);
          end else if (sp_q == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = FILL;
            idx_d   = '0;
          end
        end
      end
      SPILL: begin
        if (mem.mem_ack) begin
          if (last_word_c) begin
            state_d = IDLE;
            idx_d   = '0;
            sp_d    = sp_q + SW'(STRIDE);
            cwp_d   = cwp_inc_c;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      FILL: begin
        if (mem.mem_ack) begin
          // Fill restores the low half of window cwp-1 from the top of the stack downward
          arr_we_c    = 1'b1;
          arr_waddr_c = PW'((32'(cwp_dec_c) * STRIDE + STRIDE - 32'd1 - 32'(idx_q)) % P);
          arr_wdata_c = mem.mem_rdata;
          if (last_word_c) begin
            state_d = IDLE;
            idx_d   = '0;
            sp_d    = sp_q - SW'(STRIDE);
            cwp_d   = cwp_dec_c;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered memory-port values derived from the upcoming state and word index
  always_comb begin
    busy_d        = (state_d != IDLE);
    mem_req_d     = busy_d;
    mem_we_d      = (state_d == SPILL);
    mem_addr_d    = '0;
    mem_wdata_d   = '0;
    spill_raddr_c = PW'(phys_idx(32'(oldest_c), 32'(idx_d), STRIDE, P));
    if (state_d == SPILL) begin
      mem_addr_d  = MEM_AW'(32'(sp_d) + 32'(idx_d));
      mem_wdata_d = spill_rdata_c;
    end else if (state_d == FILL) begin
      mem_addr_d  = MEM_AW'(32'(sp_d) - 32'd1 - 32'(idx_d));
    end
  end

  // State, pointer and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cwp_q       <= '0;
      res_q       <= CW'(1);
      sp_q        <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cwp_q       <= cwp_d;
      res_q       <= res_d;
      sp_q        <= sp_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign cwp           = cwp_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule
